mips_sram_bridge: RTL
=====================

# mips_sram_bridge

Parametrised memory-side bridge between the MIPS pipeline's load/store logic and the 16-bit asynchronous SRAM model (`Ram`). It accepts one word-wide request at a time over a valid/ready handshake and splits it into 16-bit SRAM beats. It drives address, byte masks and bus direction with a programmable wait-state count, then returns read data with a single-cycle response pulse. It generalises the pipeline's fixed 16-bit RAM port to configurable word width and SRAM speed.

## Interface
Parameters:
- WORD_W, 32: request word width; must be a multiple of 16 (16, 32, 64). BEATS = WORD_W/16.
- ADDR_W, 18: SRAM address width.
- WAIT_STATES, 1: extra access cycles per beat (0–15).

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W-clog2(BEATS)  word address.
- req_wdata  in  WORD_W  write data.
- req_be  in  WORD_W/8  byte enables for writes (bit i = byte i, little-endian).
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  WORD_W  read data; meaningful with resp_valid after a read.
- addr  out  ADDR_W  SRAM address.
- data  inout  16  SRAM data bus.
- wre  out  1  write enable, active-low.
- oute  out  1  output enable, active-low.
- hb_mask  out  1  high-byte mask, active-low (0 = byte selected).
- lb_mask  out  1  low-byte mask, active-low.
- chip_en  out  1  chip enable, active-low.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RECOVER, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch the request, clear the beat index k and go to SETUP.
- SETUP: addr = req_addr*BEATS + k. chip_en=0. Masks: reads 0/0; writes lb_mask=~be[2k], hb_mask=~be[2k+1]. Reads: oute=0. Writes: data drives wdata[16k+15:16k].
- ACCESS: lasts WAIT_STATES+1 cycles, counted by a wait counter. Writes hold wre=0 throughout. Reads capture data into rdata[16k+15:16k] on the edge ending the last ACCESS cycle.
- RECOVER: chip_en=1, wre=1, oute=1, masks=1. Writes keep driving data for hold time. Then k++: go to SETUP if k<BEATS, else DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE.
- data is high-Z except during SETUP/ACCESS/RECOVER of write beats.
- resp_rdata holds its value until the next read completes. Writes leave it unchanged.
- req_ready=0 in every state except IDLE. A request stays pending until accepted.
- Beat order: low half first (k=0 is bits 15:0).

## Timing
- Per beat: 3+WAIT_STATES cycles. Completion: DONE is entered BEATS*(3+WAIT_STATES) cycles after the accepting edge. Defaults give 8 cycles, so resp_valid is high in cycle 9 and req_ready returns in cycle 10.
- Back-to-back requests: minimum 2 idle-handshake cycles between beats of consecutive requests (DONE + IDLE).
- Reset values (reset=0 at a rising edge, effective after that edge): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, addr=0, wre=1, oute=1, hb_mask=1, lb_mask=1, chip_en=1, data high-Z, counters 0.
- Reset mid-transfer: the transfer is abandoned at the next edge. No resp_valid is issued. A partially written SRAM word is allowed.
- req_valid deasserted before acceptance: no effect.

## Configuration
- SRAM_BRIDGE_BEAT_SKIP_EN defined: write beats whose two byte enables are both 0 are skipped entirely. There are no SETUP/ACCESS/RECOVER cycles and the bridge advances k in zero cycles. A write with req_be all-zero goes from IDLE directly to DONE, so resp_valid appears on the cycle after acceptance. Reads are never skipped.
- Not defined: every beat is performed. A fully-masked write beat runs with wre=0 and both masks=1, so no SRAM byte changes.

## Test plan
- Reset: hold reset=0 for 2 edges during an in-flight write. All outputs must take their reset values, data must be Z, and no resp_valid is issued.
- Write 0xDEADBEEF to word 0x10 with be=4'hF, WAIT_STATES=1. Beat 0 must be addr=0x20, data=0xBEEF; beat 1 must be addr=0x21, data=0xDEAD. wre=0 for 2 cycles per beat. resp_valid must pulse 8 cycles after acceptance.
- Read back word 0x10: oute=0 in each beat and masks 0/0. resp_rdata=0xDEADBEEF with resp_valid.
- Partial write be=4'b0100 with data 0x00AA0000, then read. Beat 1 must have lb_mask=0, hb_mask=1. Readback is 0xDEAABEEF.
- With SRAM_BRIDGE_BEAT_SKIP_EN, write be=4'b0011. Only one beat (addr=0x20) is issued and resp_valid comes 4 cycles after acceptance. With be=0, resp_valid comes 1 cycle after acceptance.
- WORD_W=64, WAIT_STATES=0: read 4 beats at addresses 4n..4n+3. resp_valid comes 12 cycles after acceptance and req_ready stays low throughout.

Source files
------------

// File: rtl/mips_sram_bridge.sv
// Word-wide request bridge onto a 16-bit asynchronous SRAM: one request at a time, split into beats.
// Optional SRAM_BRIDGE_BEAT_SKIP_EN: write beats with both byte enables clear are skipped entirely.
module mips_sram_bridge #(
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 18,
  parameter int WAIT_STATES = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_we,
  input  logic [ADDR_W-$clog2(WORD_W/16)-1:0] req_addr,
  input  logic [WORD_W-1:0]                   req_wdata,
  input  logic [WORD_W/8-1:0]                 req_be,
  output logic                                resp_valid,
  output logic [WORD_W-1:0]                   resp_rdata,
  output logic [ADDR_W-1:0]                   addr,
  inout  wire  [15:0]                         data,
  output logic                                wre,
  output logic                                oute,
  output logic                                hb_mask,
  output logic                                lb_mask,
  output logic                                chip_en
);

  localparam int BEATS  = WORD_W / 16;
  localparam int BSHIFT = $clog2(BEATS);
  localparam int RA_W   = ADDR_W - BSHIFT;
  localparam int KW     = (BEATS > 1) ? BSHIFT : 1;
  localparam int NW     = KW + 1;
  localparam int BE_W   = WORD_W / 8;

  localparam logic [NW-1:0] NO_BEAT   = NW'(BEATS);
  localparam logic [3:0]    WAIT_LAST = 4'(WAIT_STATES);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] ACCESS  = 3'd2;
  localparam logic [2:0] RECOVER = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [3:0]        wait_q, wait_d;
  logic              we_q, we_d;
  logic [RA_W-1:0]   base_q, base_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [WORD_W-1:0] rbuf_q, rbuf_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wre_q, wre_d;
  logic              oute_q, oute_d;
  logic              hb_q, hb_d;
  logic              lb_q, lb_d;
  logic              cen_q, cen_d;
  logic [15:0]       dout_q, dout_d;
  logic              doe_q, doe_d;

  logic [BEATS-1:0]  live_req;
  logic [BEATS-1:0]  live_lat;
  logic [NW-1:0]     nxt;

  // A beat is live when it must touch the SRAM; reads always are.
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_live
`ifdef SRAM_BRIDGE_BEAT_SKIP_EN
      assign live_req[gi] = !req_we || (req_be[2*gi +: 2] != 2'b00);
      assign live_lat[gi] = !we_q || (be_q[2*gi +: 2] != 2'b00);
`else
      assign live_req[gi] = 1'b1;
      assign live_lat[gi] = 1'b1;
`endif
    end
  endgenerate

  function automatic logic [NW-1:0] first_live(input logic [BEATS-1:0] live, input int start);
    logic [NW-1:0] pick;
    pick = NO_BEAT;
    for (int i = BEATS - 1; i >= 0; i--) begin
      if (i >= start && live[i]) pick = NW'(i);
    end
    return pick;
  endfunction

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wait_d  = wait_q;
    we_d    = we_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    nxt     = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          base_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          wait_d  = '0;
          nxt     = first_live(live_req, 0);
          if (nxt == NO_BEAT) begin
            k_d     = '0;
            state_d = DONE;
          end else begin
            k_d     = nxt[KW-1:0];
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        wait_d  = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (wait_q == WAIT_LAST) begin
          state_d = RECOVER;
          if (!we_q) rbuf_d[16*k_q +: 16] = data;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      RECOVER: begin
        wait_d = '0;
        nxt    = first_live(live_lat, int'(k_q) + 1);
        if (nxt == NO_BEAT) begin
          state_d = DONE;
          if (!we_q) rdata_d = rbuf_q;
        end else begin
          k_d     = nxt[KW-1:0];
          state_d = SETUP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM pins are registered from the next state so they change cleanly on the clock edge.
  always_comb begin
    addr_d = addr_q;
    wre_d  = 1'b1;
    oute_d = 1'b1;
    hb_d   = 1'b1;
    lb_d   = 1'b1;
    cen_d  = 1'b1;
    dout_d = dout_q;
    doe_d  = 1'b0;
    if (state_d == SETUP || state_d == ACCESS) begin
      addr_d = (ADDR_W'(base_d) << BSHIFT) | ADDR_W'(k_d);
      cen_d  = 1'b0;
      if (we_d) begin
        lb_d = ~be_d[2*k_d];
        hb_d = ~be_d[2*k_d+1];
        if (state_d == ACCESS) wre_d = 1'b0;
      end else begin
        lb_d   = 1'b0;
        hb_d   = 1'b0;
        oute_d = 1'b0;
      end
    end
    if (we_d && (state_d == SETUP || state_d == ACCESS || state_d == RECOVER)) begin
      doe_d  = 1'b1;
      dout_d = wdata_d[16*k_d +: 16];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      wait_q  <= '0;
      we_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wre_q   <= 1'b1;
      oute_q  <= 1'b1;
      hb_q    <= 1'b1;
      lb_q    <= 1'b1;
      cen_q   <= 1'b1;
      dout_q  <= '0;
      doe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wre_q   <= wre_d;
      oute_q  <= oute_d;
      hb_q    <= hb_d;
      lb_q    <= lb_d;
      cen_q   <= cen_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_rdata = rdata_q;
  assign addr       = addr_q;
  assign wre        = wre_q;
  assign oute       = oute_q;
  assign hb_mask    = hb_q;
  assign lb_mask    = lb_q;
  assign chip_en    = cen_q;
  assign data       = doe_q ? dout_q : 16'hzzzz;

endmodule
